// File: rtl/imu_spi_slave.sv
// SPI mode-0 responder emulating the IMU register-read port for HIL benches.
// Single-byte frames; each frame returns the register addressed by the previous frame.
module imu_spi_slave #(
  parameter logic [7:0] WHO_AM_I     = 8'h71,
  parameter logic [7:0] DEFAULT_BYTE = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_ss,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  output logic        spi_miso,
  input  logic        sample_valid,
  input  logic [47:0] acc,
  input  logic [47:0] gyr,
  input  logic [47:0] mag,
  output logic [7:0]  rx_byte,
  output logic        frame_done,
  output logic        frame_err
);

  typedef struct packed {
    logic [47:0] acc;
    logic [47:0] gyr;
    logic [47:0] mag;
  } sens_t;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  ss_p, sck_p;   // [0],[1] synchronizer, [2] previous synced value
  logic [1:0]  mosi_p;
  logic        ss_fall, ss_rise, sck_rise, sck_fall;
  logic [7:0]  tx, rx, tx_next, rd_byte;
  logic [3:0]  cnt;
  sens_t       in_set, shadow, live, live_nxt;
  logic        ld_live;

  assign in_set   = '{acc: acc, gyr: gyr, mag: mag};
  assign ss_fall  =  ss_p[2]  & ~ss_p[1];
  assign ss_rise  = ~ss_p[2]  &  ss_p[1];
  assign sck_rise = ~sck_p[2] &  sck_p[1];
  assign sck_fall =  sck_p[2] & ~sck_p[1];

  function automatic logic [7:0] byte_of(input logic [47:0] v, input logic [2:0] i);
    byte_of = 8'(v >> (6'd40 - 6'(i) * 6'd8));
  endfunction

  function automatic logic [7:0] reg_byte(input logic [6:0] a, input sens_t s);
    logic [7:0] b;
    b = DEFAULT_BYTE;
    if (a inside {[7'h3B:7'h40]})      b = byte_of(s.acc, 3'(a - 7'h3B));
    else if (a inside {[7'h43:7'h48]}) b = byte_of(s.gyr, 3'(a - 7'h43));
    else if (a inside {[7'h49:7'h4E]}) b = byte_of(s.mag, 3'(a - 7'h49));
    else if (a == 7'h75)               b = WHO_AM_I;
    return b;
  endfunction

  // A read of the first accel byte latches a coherent burst; a coincident strobe bypasses shadow.
  always_comb begin
    ld_live  = rx[7] && (rx[6:0] == 7'h3B);
    live_nxt = live;
    if (ld_live) live_nxt = sample_valid ? in_set : shadow;
    rd_byte  = reg_byte(rx[6:0], live_nxt);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ss_p   <= '0;
      sck_p  <= '0;
      mosi_p <= '0;
    end else begin
      ss_p   <= {ss_p[1:0], spi_ss};
      sck_p  <= {sck_p[1:0], spi_sck};
      mosi_p <= {mosi_p[0], spi_mosi};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ss_fall) state_nxt = SHIFT;
      SHIFT:   if (ss_rise) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    spi_miso = (state == SHIFT) ? tx[7] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx         <= '0;
      rx         <= '0;
      cnt        <= '0;
      tx_next    <= 8'h00;
      rx_byte    <= 8'h00;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      shadow     <= '0;
      live       <= '0;
    end else begin
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (sample_valid) shadow <= in_set;
      case (state)
        IDLE: if (ss_fall) begin
          tx  <= tx_next;
          cnt <= '0;
        end
        SHIFT: if (ss_rise) begin
          if (cnt == 4'd8) begin
            rx_byte    <= rx;
            frame_done <= 1'b1;
            live       <= live_nxt;
            tx_next    <= rx[7] ? rd_byte : DEFAULT_BYTE;
          end else begin
            frame_err  <= 1'b1;
            tx_next    <= DEFAULT_BYTE;
          end
        end else begin
          if (sck_rise) begin
            rx <= {rx[6:0], mosi_p[1]};
            if (cnt != 4'd15) cnt <= cnt + 4'd1;
          end
          if (sck_fall) tx <= {tx[6:0], 1'b0};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/imu_spi_slave.md
# imu_spi_slave

SPI responder that emulates the IMU's register-read interface so the avionics SPI master can be exercised against known sensor data in hardware-in-the-loop builds and benches. It speaks the master's single-byte, pipelined read protocol: slave-select frames every byte, and the byte returned in each frame is the register addressed in the previous frame. Sensor values come from parallel 48-bit inputs and are captured coherently per burst.

## Interface
- `WHO_AM_I`, 8'h71: value returned for address 0x75.
- `DEFAULT_BYTE`, 8'h00: value returned for unmapped addresses, for write frames, and after aborted frames.
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-low; acts only on a rising `clk` edge while `rst` is 0.
- `spi_ss` input 1: slave select, active-low, asynchronous to `clk`.
- `spi_sck` input 1: SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous.
- `spi_mosi` input 1: master data, MSB first.
- `spi_miso` output 1: slave data, MSB first; 0 while deselected.
- `sample_valid` input 1: 1-cycle strobe that loads `acc`/`gyr`/`mag` into the shadow set.
- `acc` input 48: {X[15:0], Y[15:0], Z[15:0]}, each axis high byte first.
- `gyr` input 48: same layout as `acc`.
- `mag` input 48: same layout as `acc`.
- `rx_byte` output 8: last complete byte received.
- `frame_done` output 1: 1-cycle pulse when a complete 8-bit frame ends.
- `frame_err` output 1: 1-cycle pulse when a frame ends with a bit count other than 8.

## Operation
- Input sync: `spi_ss`, `spi_sck`, `spi_mosi` each pass through 2 flops. `ss` sync flops reset to 0, so a select held low through reset never produces a falling edge. `sck` sync flops reset to 0. Edges are detected from the synced value and its previous value.
- FSM `IDLE`:
  - Synced `ss` falling: load tx shift register with `tx_next`, clear the 4-bit bit counter, go to `SHIFT`.
- FSM `SHIFT`:
  - `sck` rising: shift synced `mosi` into the rx register LSB-side, increment the bit counter, saturating at 15.
  - `sck` falling: shift tx left by one.
  - `spi_miso` = tx[7].
  - Synced `ss` rising: return to `IDLE` and evaluate the end-of-frame rules below.
- End of frame, count == 8:
  - `rx_byte` <= rx; pulse `frame_done`.
  - If rx[7] = 1 (read), `tx_next` <= reg(rx[6:0]). Otherwise `tx_next` <= `DEFAULT_BYTE`.
- End of frame, count != 8 (abort or over-clock): pulse `frame_err`; `tx_next` <= `DEFAULT_BYTE`; `rx_byte` unchanged.
- Register map, read-only:
  - 0x3B–0x40: live `acc` bytes [47:40] … [7:0].
  - 0x43–0x48: live `gyr` bytes.
  - 0x49–0x4E: live `mag` bytes.
  - 0x75: `WHO_AM_I`.
  - All other addresses: `DEFAULT_BYTE`.
- Shadow and live sets:
  - `sample_valid` copies the inputs into shadow.
  - A decoded read of 0x3B copies shadow into live in the same cycle. `tx_next` uses the newly copied value.
  - If `sample_valid` coincides with a 0x3B decode, the live set and `tx_next` take the input values directly (bypass).
  - Mid-burst `sample_valid` never alters the live set.
- `spi_miso` is 0 in `IDLE`.

## Timing
- Reset values:
  - `spi_miso`, `frame_done`, `frame_err`: 0.
  - `rx_byte`, `tx_next`: 8'h00.
  - Shadow and live sets: 0.
  - FSM: `IDLE`; bit counter: 0.
- Pin-to-action latency is 3 `clk` (2 sync + 1 edge register) for both `ss` and `sck` edges.
- `frame_done`/`frame_err` assert 3 `clk` after the `spi_ss` rising pin edge, for exactly 1 cycle.
- `spi_miso` first bit is valid 3 `clk` after the `spi_ss` fall. Later bits are valid 3 `clk` after each `spi_sck` fall.
- Master requirements:
  - `sck` half-period ≥ 4 `clk`.
  - `ss` fall to first `sck` rise ≥ 4 `clk`.
  - `ss` high time ≥ 2 `clk`.
- `tx_next` is valid 1 `clk` after the end-of-frame decode, before any following `ss` fall can be detected.
- Reset mid-frame: FSM returns to `IDLE` and partial data is discarded. No new frame starts until `spi_ss` has been seen high, then low.

## Test plan
- Burst read:
  - Stimulus: load `acc`=48'h010203040506 via `sample_valid`; frames 0xBB, 0xBC, 0xBD, 0xBE, 0xBF, 0xC0, 0xFF.
  - Required: MISO bytes 0x00, 0x01, 0x02, 0x03, 0x04, 0x05, 0x06; seven `frame_done` pulses; `rx_byte`=0xFF at end.
- ID:
  - Stimulus: frames 0xF5, 0xFF.
  - Required: second frame returns 0x71. Repeat with `WHO_AM_I`=8'hA5 → 0xA5.
- Write/unmapped:
  - Stimulus: frames 0x3B (write bit 0), 0xFF.
  - Required: second returns 0x00. Frames 0xA0, 0xFF also return 0x00.
- Coherency:
  - Stimulus: after the 0xBB frame, pulse `sample_valid` with `acc`=48'hAAAA_BBBB_CCCC.
  - Required: current burst still returns the old bytes. Next burst returns AA AA BB BB CC CC.
- Abort:
  - Stimulus: `ss` rises after 5 `sck` edges.
  - Required: `frame_err` pulse, no `frame_done`, `rx_byte` unchanged, next frame returns 0x00. `sample_valid` coinciding with a 0x3B decode → bypass value returned.
- Reset:
  - Stimulus: assert `rst`=0 mid-frame with `ss` held low.
  - Required: no pulses and `spi_miso`=0 until `ss` goes high then low. The next full frame behaves normally.
